dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Sequences and shares the single-port data RAM (word-addressed, combinational read, synchronous write) between two requesters: the CPU load/store unit (port c) and the debug/DMA loader (port d).
- Arbitrates round-robin and turns byte/halfword stores into read-modify-write word writes.
- Checks address range and strobe legality, and returns registered read data with a one-cycle response pulse.
- Sits between the requesters and the DataMem instance; it owns mem_we, mem_adr and mem_din.

Parameters:
- ADDR_W, 14, word-address width of the RAM; legal byte addresses have adr[31:ADDR_W+2] == 0. The debug build sets it to 16.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- c_req  in  1  CPU request; held until c_gnt
- c_we  in  1  1 = store, 0 = load
- c_be  in  4  byte strobes for stores, bit i = byte i; ignored for loads
- c_adr  in  32  byte address; bits [1:0] ignored
- c_wdata  in  32  store data, lane-aligned (byte i in bits 8i+7:8i)
- c_gnt  out  1  request accepted this cycle
- c_rvalid  out  1  one-cycle response pulse
- c_rdata  out  32  full read word, valid with c_rvalid
- c_err  out  1  access rejected, valid with c_rvalid
- d_req, d_we, d_be, d_adr, d_wdata, d_gnt, d_rvalid, d_rdata, d_err: identical set for the debug/DMA port
- mem_we  out  1  RAM write enable
- mem_adr  out  32  byte address to RAM; the RAM uses bits [ADDR_W+1:2]
- mem_din  out  32  merged write word
- mem_rd  in  32  RAM combinational read data

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state = IDLE; last = d, so the CPU wins the first tie; latched request registers = 0; rdata_q = 0; err_q = 0.
  - All outputs are 0 during reset, including mem_we and the gnt/rvalid signals.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - x_gnt is asserted combinationally when x is selected and x_req = 1.
  - Selection: if only one requester is active, it wins. If both are active, the requester not equal to last wins.
  - On the clock edge the block latches owner, we, be, adr and wdata, updates last = owner, and moves to ACCESS.
  - With no request it stays in IDLE.
- ACCESS:
  - mem_adr = latched adr with bits [1:0] forced to 0.
  - mem_din: byte i = wdata byte i if be[i], else mem_rd byte i.
  - mem_we = we & legal, for exactly this one cycle.
  - legal = range_ok & (be is one of 0001, 0010, 0100, 1000, 0011, 1100, 1111).
  - range_ok = (adr[31:ADDR_W+2] == 0).
  - Loads: legal = range_ok; be is ignored.
  - On the edge, rdata_q takes mem_rd (the pre-write word for stores) and err_q takes ~legal. Next state is DONE.
- DONE:
  - owner_rvalid = 1, owner_rdata = rdata_q, owner_err = err_q. The non-owner's rvalid stays 0.
  - Next state is IDLE unconditionally; no grant is given in DONE.
- Latency: gnt in cycle T; the RAM write commits at the end of T+1; rvalid in T+2. The earliest next grant is T+3, so throughput is one access per 3 cycles.
- Illegal access: no RAM write, rvalid still pulses with err = 1, and rdata = the addressed word if range_ok, else 0.
  - For out-of-range accesses, mem_adr is still driven but must not be written.
- Requests arriving while the FSM is in ACCESS or DONE wait; they are not granted and not dropped while req is held.
- x_rdata outputs are 0 whenever x_rvalid = 0.
- Reset mid-operation: an asynchronous return to IDLE. mem_we drops immediately, the pending response is discarded, and last returns to d.
- Requester protocol: req, we, be, adr and wdata are sampled only in the grant cycle. Dropping req before grant withdraws the request with no side effect.

Test Plan:
- Reset, then c_req=1, c_we=0, c_adr=0x0000_0010 with RAM[4]=0xDEADBEEF: c_gnt at T, mem_we=0 throughout, c_rvalid at T+2 with c_rdata=0xDEADBEEF and c_err=0.
- CPU store c_be=0010, c_wdata=0x0000AB00 to 0x20 with RAM[8]=0x11223344: mem_we=1 only in T+1 with mem_din=0x1122AB44; a following read returns 0x1122AB44.
- c_req and d_req both held for 4 accesses from reset: grants go c, d, c, d, each 3 cycles apart; rvalid pulses only on the owner's port.
- Store with be=0101 to 0x40, and a store to adr=1<<(ADDR_W+2): mem_we never asserts, rvalid+err=1 at T+2, RAM contents unchanged.
- rst_n pulled low during ACCESS of a store: mem_we goes 0 immediately, no rvalid follows, and after release the next tie is granted to c.
- d_req asserted during a CPU access in ACCESS: no d_gnt until IDLE at T+3; d_gnt then asserts and d completes 2 cycles later.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin CPU/debug arbiter and RMW sequencer for the single-port data RAM
module dmem_arbiter #(
    parameter int ADDR_W = 14
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [3:0]  c_be,
    input  logic [31:0] c_adr,
    input  logic [31:0] c_wdata,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic [31:0] c_rdata,
    output logic        c_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_adr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_we,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_rd
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state, state_nx;
    logic        last_d;
    logic        owner_d;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:2] adr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        sel_d;
    logic        any_req;
    logic        range_ok;
    logic        be_ok;
    logic        legal;
    logic [31:0] merged;

    // Debug wins only when it is alone or the CPU had the previous turn.
    assign sel_d   = d_req & (~c_req | ~last_d);
    assign any_req = c_req | d_req;

    assign range_ok = (adr_q[31:ADDR_W+2] == '0);

    always_comb begin
        be_ok = 1'b0;
        case (be_q)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: be_ok = 1'b1;
            default:                   be_ok = 1'b0;
        endcase
    end

    assign legal = range_ok & (~we_q | be_ok);

    always_comb begin
        merged = mem_rd;
        for (int i = 0; i < 4; i++) begin
            if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
        end
    end

    always_comb begin
        state_nx = state;
        c_gnt    = 1'b0;
        d_gnt    = 1'b0;
        c_rvalid = 1'b0;
        c_rdata  = '0;
        c_err    = 1'b0;
        d_rvalid = 1'b0;
        d_rdata  = '0;
        d_err    = 1'b0;
        mem_we   = 1'b0;
        mem_adr  = '0;
        mem_din  = '0;
        case (state)
            IDLE: begin
                // rst_n gating keeps grants quiet while reset is asserted.
                if (rst_n && any_req) begin
                    c_gnt    = ~sel_d;
                    d_gnt    = sel_d;
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                mem_adr  = {adr_q, 2'b00};
                mem_din  = merged;
                mem_we   = we_q & legal;
                state_nx = DONE;
            end
            DONE: begin
                if (owner_d) begin
                    d_rvalid = 1'b1;
                    d_rdata  = rdata_q;
                    d_err    = err_q;
                end else begin
                    c_rvalid = 1'b1;
                    c_rdata  = rdata_q;
                    c_err    = err_q;
                end
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            last_d  <= 1'b1;
            owner_d <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            adr_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && any_req) begin
                owner_d <= sel_d;
                last_d  <= sel_d;
                we_q    <= sel_d ? d_we      : c_we;
                be_q    <= sel_d ? d_be      : c_be;
                adr_q   <= sel_d ? d_adr[31:2] : c_adr[31:2];
                wdata_q <= sel_d ? d_wdata   : c_wdata;
            end
            if (state == ACCESS) begin
                // Read data is the pre-write word; out-of-range reads return zero.
                rdata_q <= range_ok ? mem_rd : '0;
                err_q   <= ~legal;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed table-driven bench for dmem_arbiter
module tb_dmem_arbiter;

    localparam int ADDR_W = 14;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        c_req = 0, c_we = 0;
    logic [3:0]  c_be = '0;
    logic [31:0] c_adr = '0, c_wdata = '0;
    logic        c_gnt, c_rvalid, c_err;
    logic [31:0] c_rdata;
    logic        d_req = 0, d_we = 0;
    logic [3:0]  d_be = '0;
    logic [31:0] d_adr = '0, d_wdata = '0;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        mem_we;
    logic [31:0] mem_adr, mem_din, mem_rd;

    logic [31:0] ram [0:(1<<ADDR_W)-1];

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign mem_rd = ram[mem_adr[ADDR_W+1:2]];
    always @(posedge clk) if (mem_we) ram[mem_adr[ADDR_W+1:2]] <= mem_din;

    dmem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_be(c_be), .c_adr(c_adr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_adr(d_adr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_we(mem_we), .mem_adr(mem_adr), .mem_din(mem_din), .mem_rd(mem_rd)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [3:0]  be;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
        bit          exp_we;
        logic [31:0] exp_din;
    } vec_t;

    vec_t vecs [14];

    task automatic run_vec(input int i, input vec_t v);
        int   n;
        logic g;
        if (v.port) begin
            d_we = v.we; d_be = v.be; d_adr = v.adr; d_wdata = v.wdata; d_req = 1'b1;
        end else begin
            c_we = v.we; c_be = v.be; c_adr = v.adr; c_wdata = v.wdata; c_req = 1'b1;
        end
        #1;
        n = 0;
        g = v.port ? d_gnt : c_gnt;
        while (!g && n < 10) begin
            @(negedge clk); #1;
            n++;
            g = v.port ? d_gnt : c_gnt;
        end
        chk($sformatf("v%0d_gnt", i), {31'b0, g}, 32'd1);
        if (!g) begin
            c_req = 1'b0; d_req = 1'b0;
            @(negedge clk);
            return;
        end
        @(negedge clk);
        c_req = 1'b0; d_req = 1'b0;
        #1;
        chk($sformatf("v%0d_mem_we", i), {31'b0, mem_we}, {31'b0, v.exp_we});
        if (v.exp_we) chk($sformatf("v%0d_mem_din", i), mem_din, v.exp_din);
        @(negedge clk); #1;
        chk($sformatf("v%0d_rvalid", i), {31'b0, v.port ? d_rvalid : c_rvalid}, 32'd1);
        chk($sformatf("v%0d_other_rvalid", i), {31'b0, v.port ? c_rvalid : d_rvalid}, 32'd0);
        chk($sformatf("v%0d_rdata", i), v.port ? d_rdata : c_rdata, v.exp_rdata);
        chk($sformatf("v%0d_err", i), {31'b0, v.port ? d_err : c_err}, {31'b0, v.exp_err});
        chk($sformatf("v%0d_mem_we_done", i), {31'b0, mem_we}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < (1<<ADDR_W); i++) ram[i] = '0;
        ram[0]  = 32'h5555_5555;
        ram[4]  = 32'hDEAD_BEEF;
        ram[8]  = 32'h1122_3344;
        ram[12] = 32'h7777_7777;
        ram[16] = 32'hAABB_CCDD;

        vecs[0]  = '{0, 0, 4'b0000, 32'h0000_0010, 32'h0,          32'hDEAD_BEEF, 0, 0, 32'h0};
        vecs[1]  = '{0, 1, 4'b0010, 32'h0000_0020, 32'h0000_AB00, 32'h1122_3344, 0, 1, 32'h1122_AB44};
        vecs[2]  = '{0, 0, 4'b0000, 32'h0000_0020, 32'h0,          32'h1122_AB44, 0, 0, 32'h0};
        vecs[3]  = '{1, 1, 4'b1111, 32'h0000_0024, 32'hCAFE_F00D, 32'h0,          0, 1, 32'hCAFE_F00D};
        vecs[4]  = '{1, 0, 4'b0000, 32'h0000_0024, 32'h0,          32'hCAFE_F00D, 0, 0, 32'h0};
        vecs[5]  = '{0, 1, 4'b0101, 32'h0000_0040, 32'h00FF_00FF, 32'hAABB_CCDD, 1, 0, 32'h0};
        vecs[6]  = '{0, 0, 4'b0000, 32'h0000_0040, 32'h0,          32'hAABB_CCDD, 0, 0, 32'h0};
        vecs[7]  = '{1, 1, 4'b1111, 32'h0001_0000, 32'h1234_5678, 32'h0,          1, 0, 32'h0};
        vecs[8]  = '{0, 0, 4'b0000, 32'h0000_0000, 32'h0,          32'h5555_5555, 0, 0, 32'h0};
        vecs[9]  = '{0, 1, 4'b1100, 32'h0000_0040, 32'h1234_0000, 32'hAABB_CCDD, 0, 1, 32'h1234_CCDD};
        vecs[10] = '{1, 0, 4'b0000, 32'h0000_0043, 32'h0,          32'h1234_CCDD, 0, 0, 32'h0};
        vecs[11] = '{0, 0, 4'b0000, 32'h8000_0000, 32'h0,          32'h0,          1, 0, 32'h0};
        vecs[12] = '{0, 1, 4'b0001, 32'h0000_0010, 32'h0000_00EE, 32'hDEAD_BEEF, 0, 1, 32'hDEAD_BEEE};
        vecs[13] = '{0, 1, 4'b0000, 32'h0000_0010, 32'hFFFF_FFFF, 32'hDEAD_BEEE, 1, 0, 32'h0};

        // Reset state, with a request pending that must not be granted
        c_req = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_c_gnt", {31'b0, c_gnt}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_c_rvalid", {31'b0, c_rvalid}, 32'd0);
        chk("rst_c_rdata", c_rdata, 32'h0);
        chk("rst_mem_adr", mem_adr, 32'h0);
        c_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Both requesters held: grants alternate c, d, c, d three cycles apart
        c_we = 0; c_adr = 32'h10; d_we = 0; d_adr = 32'h20;
        c_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < 12; k++) begin
            bit eg_c, eg_d, ev_c, ev_d;
            #1;
            eg_c = (k % 3 == 0) && ((k / 3) % 2 == 0);
            eg_d = (k % 3 == 0) && ((k / 3) % 2 == 1);
            ev_c = (k % 3 == 2) && ((k / 3) % 2 == 0);
            ev_d = (k % 3 == 2) && ((k / 3) % 2 == 1);
            chk($sformatf("rr%0d_c_gnt", k), {31'b0, c_gnt}, {31'b0, eg_c});
            chk($sformatf("rr%0d_d_gnt", k), {31'b0, d_gnt}, {31'b0, eg_d});
            chk($sformatf("rr%0d_c_rvalid", k), {31'b0, c_rvalid}, {31'b0, ev_c});
            chk($sformatf("rr%0d_d_rvalid", k), {31'b0, d_rvalid}, {31'b0, ev_d});
            chk($sformatf("rr%0d_c_rdata", k), c_rdata, ev_c ? 32'hDEAD_BEEF : 32'h0);
            chk($sformatf("rr%0d_d_rdata", k), d_rdata, ev_d ? 32'h1122_3344 : 32'h0);
            chk($sformatf("rr%0d_mem_we", k), {31'b0, mem_we}, 32'd0);
            @(negedge clk);
        end
        c_req = 1'b0; d_req = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);
        chk("ram_oob_untouched", ram[0], 32'h5555_5555);
        chk("ram_badbe_untouched", ram[4], 32'hDEAD_BEEE);

        // Debug request arriving mid-access waits until the FSM is back in IDLE
        c_we = 0; c_adr = 32'h10; c_req = 1'b1;
        #1;
        chk("wait_c_gnt", {31'b0, c_gnt}, 32'd1);
        @(negedge clk);
        c_req = 1'b0;
        d_we = 0; d_adr = 32'h20; d_req = 1'b1;
        #1;
        chk("wait_d_gnt_t1", {31'b0, d_gnt}, 32'd0);
        @(negedge clk); #1;
        chk("wait_d_gnt_t2", {31'b0, d_gnt}, 32'd0);
        chk("wait_c_rvalid_t2", {31'b0, c_rvalid}, 32'd1);
        @(negedge clk); #1;
        chk("wait_d_gnt_t3", {31'b0, d_gnt}, 32'd1);
        @(negedge clk);
        d_req = 1'b0;
        #1;
        chk("wait_d_rvalid_t4", {31'b0, d_rvalid}, 32'd0);
        @(negedge clk); #1;
        chk("wait_d_rvalid_t5", {31'b0, d_rvalid}, 32'd1);
        chk("wait_d_rdata_t5", d_rdata, 32'h1122_AB44);
        @(negedge clk);

        // Reset during ACCESS of a CPU store: write aborted, no response, tie back to c
        c_we = 1; c_be = 4'b1111; c_adr = 32'h30; c_wdata = 32'h9999_9999; c_req = 1'b1;
        #1;
        chk("abort_c_gnt", {31'b0, c_gnt}, 32'd1);
        @(negedge clk); #1;
        chk("abort_mem_we_pre", {31'b0, mem_we}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_mem_we_rst", {31'b0, mem_we}, 32'd0);
        chk("abort_c_gnt_rst", {31'b0, c_gnt}, 32'd0);
        @(negedge clk);
        c_req = 1'b0;
        rst_n = 1'b1;
        chk("abort_ram_kept", ram[12], 32'h7777_7777);
        #1;
        chk("abort_rvalid_a", {31'b0, c_rvalid}, 32'd0);
        @(negedge clk); #1;
        chk("abort_rvalid_b", {31'b0, c_rvalid}, 32'd0);
        @(negedge clk);
        c_we = 0; c_adr = 32'h10; d_we = 0; d_adr = 32'h20;
        c_req = 1'b1; d_req = 1'b1;
        #1;
        chk("abort_tie_c_gnt", {31'b0, c_gnt}, 32'd1);
        chk("abort_tie_d_gnt", {31'b0, d_gnt}, 32'd0);
        @(negedge clk);
        c_req = 1'b0; d_req = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
